// File: rtl/maze_pkg.sv
// Shared maze definitions: BRAM geometry, maze word bit fields and the
// state encoding of the maze BRAM arbiter.
//
// Contents:
//   MAZE_ADDR_W / MAZE_DATA_W  BRAM address / word width (256 x 9)
//   MAZE_SIZE                  maze edge length in cells (16 x 16)
//   WALL_BIT, COLL_LSB/MSB     fields of a maze word
//   arb_state_t                arbiter FSM states IDLE / ISSUE / WAIT
//   maze_addr()                cell (x, y) to BRAM address, addr = y*16 + x
package maze_pkg;

    localparam int MAZE_ADDR_W = 8;
    localparam int MAZE_DATA_W = 9;
    localparam int MAZE_SIZE   = 16;

    localparam int WALL_BIT = 0;
    localparam int COLL_LSB = 1;
    localparam int COLL_MSB = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    function automatic logic [MAZE_ADDR_W-1:0] maze_addr(input logic [3:0] x,
                                                         input logic [3:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/maze_bram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Scans the request vector starting at the pointer, wrapping modulo NUM_REQ,
// and returns the first asserted requester.
//
// Ports:
//   i_req  in   NUM_REQ  request vector
//   i_ptr  in   IDX_W    index where the search starts
//   o_gnt  out  NUM_REQ  one-hot winner (all zero when nothing requests)
//   o_idx  out  IDX_W    binary index of the winner
//   o_vld  out  1        at least one request present
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_vld
);

    always_comb begin
        int j;
        o_gnt = '0;
        o_idx = '0;
        o_vld = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(i_ptr) + i) % NUM_REQ;
            if (!o_vld && i_req[j]) begin
                o_vld    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/maze_bram_arbiter.sv
// maze_bram_arbiter: single-port arbiter for the 256x9 maze BRAM, shared by
// the player mover (requester 0) and the enemy movers. One read or write is
// accepted at a time, round-robin, driven onto the BRAM port for one cycle,
// and completed with a per-requester done pulse after BRAM_LAT cycles.
//
// Build option: define PLAYER_PRIORITY_EN to let requester 0 win every idle
// arbitration; the remaining requesters then share round-robin among
// themselves. Undefined: pure round-robin over all requesters.
//
// Ports:
//   mvmt_clk   in   1               movement clock
//   reset      in   1               asynchronous, active-high
//   en         in   1               low blocks new grants
//   req        in   NUM_REQ         request level per requester
//   req_we     in   NUM_REQ         1 = write, 0 = read
//   req_addr   in   NUM_REQ*ADDR_W  packed addresses
//   req_din    in   NUM_REQ*DATA_W  packed write data
//   gnt        out  NUM_REQ         one-hot pulse: request accepted
//   done       out  NUM_REQ         one-hot pulse: transaction complete
//   rdata      out  DATA_W          last read data, held between reads
//   busy       out  1               transaction in flight
//   bram_en    out  1               BRAM enable
//   bram_we    out  1               BRAM write enable
//   bram_addr  out  ADDR_W          BRAM address (held when idle)
//   bram_din   out  DATA_W          BRAM write data (held when idle)
//   bram_dout  in   DATA_W          BRAM read data
module maze_bram_arbiter
    import maze_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = MAZE_ADDR_W,
    parameter int DATA_W   = MAZE_DATA_W,
    parameter int BRAM_LAT = 1
) (
    input  logic                      mvmt_clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_din,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic                      bram_en,
    output logic                      bram_we,
    output logic [ADDR_W-1:0]         bram_addr,
    output logic [DATA_W-1:0]         bram_din,
    input  logic [DATA_W-1:0]         bram_dout
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (BRAM_LAT > 1) ? $clog2(BRAM_LAT) : 1;

    arb_state_t         r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_sel;
    logic               r_we;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_done;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_bram_en;
    logic               r_bram_we;
    logic [ADDR_W-1:0]  r_bram_addr;
    logic [DATA_W-1:0]  r_bram_din;

    logic [NUM_REQ-1:0] w_rr_req;
    logic [NUM_REQ-1:0] w_rr_gnt;
    logic [IDX_W-1:0]   w_rr_idx;
    logic               w_rr_vld;

    logic [NUM_REQ-1:0] w_pick_gnt;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_vld;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_req (w_rr_req),
        .i_ptr (r_ptr),
        .o_gnt (w_rr_gnt),
        .o_idx (w_rr_idx),
        .o_vld (w_rr_vld)
    );

`ifdef PLAYER_PRIORITY_EN
    // The player is taken out of the rotation and overrides it when present.
    assign w_rr_req   = {req[NUM_REQ-1:1], 1'b0};
    assign w_pick_vld = req[0] | w_rr_vld;
    assign w_pick_gnt = req[0] ? NUM_REQ'(1) : w_rr_gnt;
    assign w_pick_idx = req[0] ? '0 : w_rr_idx;
`else
    assign w_rr_req   = req;
    assign w_pick_vld = w_rr_vld;
    assign w_pick_gnt = w_rr_gnt;
    assign w_pick_idx = w_rr_idx;
`endif

    always_ff @(posedge mvmt_clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_sel       <= '0;
            r_we        <= 1'b0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_rdata     <= '0;
            r_bram_en   <= 1'b0;
            r_bram_we   <= 1'b0;
            r_bram_addr <= '0;
            r_bram_din  <= '0;
        end else begin
            // gnt and done are single-cycle pulses
            r_gnt  <= '0;
            r_done <= '0;
            case (r_state)
                IDLE: begin
                    if (en && w_pick_vld) begin
                        r_gnt       <= w_pick_gnt;
                        r_sel       <= w_pick_idx;
                        r_we        <= req_we[w_pick_idx];
                        r_bram_en   <= 1'b1;
                        r_bram_we   <= req_we[w_pick_idx];
                        r_bram_addr <= req_addr[w_pick_idx*ADDR_W +: ADDR_W];
                        r_bram_din  <= req_din[w_pick_idx*DATA_W +: DATA_W];
`ifdef PLAYER_PRIORITY_EN
                        // Player grants leave the enemy rotation untouched;
                        // the pointer never lands on the player.
                        if (w_pick_idx != '0)
                            r_ptr <= (int'(w_pick_idx) == NUM_REQ-1) ? IDX_W'(1)
                                                                     : w_pick_idx + IDX_W'(1);
`else
                        r_ptr <= (int'(w_pick_idx) == NUM_REQ-1) ? '0
                                                                 : w_pick_idx + IDX_W'(1);
`endif
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // BRAM samples the command at this edge
                    r_bram_en <= 1'b0;
                    r_bram_we <= 1'b0;
                    r_cnt     <= CNT_W'(BRAM_LAT-1);
                    r_state   <= WAIT;
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        if (!r_we)
                            r_rdata <= bram_dout;
                        r_done  <= NUM_REQ'(1) << r_sel;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign rdata     = r_rdata;
    assign busy      = (r_state != IDLE);
    assign bram_en   = r_bram_en;
    assign bram_we   = r_bram_we;
    assign bram_addr = r_bram_addr;
    assign bram_din  = r_bram_din;

endmodule

// File: tb/tb_maze_bram_arbiter.sv
`timescale 1ns/1ps
module tb_maze_bram_arbiter;

    typedef struct {
        int         idx;
        logic [8:0] data;
        int         cyc;
    } ev_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        en;
    logic [3:0]  req, req_we;
    logic [31:0] req_addr;
    logic [35:0] req_din;
    logic [3:0]  gnt, done;
    logic [8:0]  rdata;
    logic        busy, bram_en, bram_we;
    logic [7:0]  bram_addr;
    logic [8:0]  bram_din, bram_dout;

    // second instance with BRAM_LAT = 3
    logic [3:0]  x_req, x_we;
    logic [31:0] x_addr;
    logic [35:0] x_din;
    logic [3:0]  x_gnt, x_done;
    logic [8:0]  x_rdata, x_bdin, x_dout;
    logic        x_busy, x_ben, x_bwe;
    logic [7:0]  x_baddr;
    logic [8:0]  x_p0, x_p1, x_p2;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    ev_t gnt_log[$];
    ev_t done_log[$];
    int  we_log[$];
    int         exp_idx[$];
    logic [8:0] exp_dat[$];

    maze_bram_arbiter dut (
        .mvmt_clk(clk), .reset(reset), .en(en),
        .req(req), .req_we(req_we), .req_addr(req_addr), .req_din(req_din),
        .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout)
    );

    maze_bram_arbiter #(.BRAM_LAT(3)) dut3 (
        .mvmt_clk(clk), .reset(reset), .en(1'b1),
        .req(x_req), .req_we(x_we), .req_addr(x_addr), .req_din(x_din),
        .gnt(x_gnt), .done(x_done), .rdata(x_rdata), .busy(x_busy),
        .bram_en(x_ben), .bram_we(x_bwe), .bram_addr(x_baddr),
        .bram_din(x_bdin), .bram_dout(x_dout)
    );

    // Unwritten cells read back as a fixed pattern of their address.
    function automatic logic [8:0] pat(input logic [7:0] a);
        return {1'b0, a} ^ 9'h026;
    endfunction

    function automatic int oh2idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    // BRAM model, latency 1
    logic [8:0] mem   [256];
    logic       wflag [256];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) wflag[i] = 1'b0;
        end else if (bram_en) begin
            bram_dout <= wflag[bram_addr] ? mem[bram_addr] : pat(bram_addr);
            if (bram_we) begin
                mem[bram_addr]   = bram_din;
                wflag[bram_addr] = 1'b1;
            end
        end
    end

    // BRAM model, latency 3 (read-only pattern)
    always @(posedge clk) begin
        if (x_ben) x_p0 <= pat(x_baddr);
        x_p1 <= x_p0;
        x_p2 <= x_p1;
    end
    assign x_dout = x_p2;

    always @(posedge clk) cyc <= cyc + 1;

    // event logger for the latency-1 instance
    always @(negedge clk) begin
        if (!reset) begin
            if (gnt != 4'b0)  gnt_log.push_back('{oh2idx(gnt), 9'h0, cyc});
            if (done != 4'b0) done_log.push_back('{oh2idx(done), rdata, cyc});
            if (bram_en && bram_we) we_log.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_all();
        gnt_log.delete();
        done_log.delete();
        we_log.delete();
        exp_idx.delete();
        exp_dat.delete();
    endtask

    task automatic do_reset();
        step();
        reset    = 1'b1;
        en       = 1'b1;
        req      = 4'b0;
        req_we   = 4'b0;
        x_req    = 4'b0;
        step();
        step();
        reset = 1'b0;
        clear_all();
    endtask

    task automatic post(input int i, input logic we, input logic [7:0] a, input logic [8:0] d);
        req[i]           = 1'b1;
        req_we[i]        = we;
        req_addr[i*8 +: 8] = a;
        req_din[i*9 +: 9]  = d;
    endtask

    task automatic expect_done(input int i, input logic [8:0] d);
        exp_idx.push_back(i);
        exp_dat.push_back(d);
    endtask

    task automatic run_until(input int n, input bit on_gnt, input bit auto_drop,
                             input int budget, input string tag);
        int c;
        c = 0;
        while (((on_gnt ? gnt_log.size() : done_log.size()) < n) && c < budget) begin
            step();
            if (auto_drop) req = req & ~gnt;
            c++;
        end
        n_cmp++;
        if ((on_gnt ? gnt_log.size() : done_log.size()) < n) begin
            n_bad++;
            $display("FAIL %s_timeout: got %0d events, required %0d", tag,
                     on_gnt ? gnt_log.size() : done_log.size(), n);
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        en     = 1'b0;
        req    = 4'b0;
        req_we = 4'b0;
        req_addr = '0;
        req_din  = '0;
        x_req  = 4'b0;
        x_we   = 4'b0;
        x_addr = '0;
        x_din  = '0;
        step();
        step();
        n_cmp++;
        if ({gnt, done, bram_en, bram_we, busy} !== 11'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b required 0", {gnt, done, bram_en, bram_we, busy});
        end
        n_cmp++;
        if (rdata !== 9'h0) begin
            n_bad++;
            $display("FAIL reset_rdata: got %h required 000", rdata);
        end
        n_cmp++;
        if (bram_addr !== 8'h0 || bram_din !== 9'h0) begin
            n_bad++;
            $display("FAIL reset_bram: addr %h din %h required 00 000", bram_addr, bram_din);
        end
    endtask

    task automatic test_single_read();
        ev_t ev;
        int  ei;
        logic [8:0] ed;
        do_reset();
        post(0, 1'b0, 8'h23, 9'h0);
        expect_done(0, 9'h005);
        step();
        n_cmp++;
        if (gnt !== 4'b0001 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL t1_gnt: gnt %b busy %b required 0001 1", gnt, busy);
        end
        n_cmp++;
        if (bram_en !== 1'b1 || bram_we !== 1'b0 || bram_addr !== 8'h23) begin
            n_bad++;
            $display("FAIL t1_bram: en %b we %b addr %h required 1 0 23", bram_en, bram_we, bram_addr);
        end
        req[0] = 1'b0;
        step();
        n_cmp++;
        if (done !== 4'b0 || busy !== 1'b1 || bram_en !== 1'b0) begin
            n_bad++;
            $display("FAIL t1_mid: done %b busy %b en %b required 0000 1 0", done, busy, bram_en);
        end
        step();
        n_cmp++;
        if (done !== 4'b0001 || rdata !== 9'h005 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL t1_done: done %b rdata %h busy %b required 0001 005 0", done, rdata, busy);
        end
        n_cmp++;
        if (done_log.size() != 1 || gnt_log.size() != 1 ||
            done_log[0].cyc - gnt_log[0].cyc != 2) begin
            n_bad++;
            $display("FAIL t1_latency: %0d done / %0d gnt events, required one each 2 cycles apart",
                     done_log.size(), gnt_log.size());
        end
        while (exp_idx.size() > 0 && done_log.size() > 0) begin
            ev = done_log.pop_front();
            ei = exp_idx.pop_front();
            ed = exp_dat.pop_front();
            n_cmp++;
            if (ev.idx !== ei || ev.data !== ed) begin
                n_bad++;
                $display("FAIL t1_sb: idx %0d data %h required idx %0d data %h", ev.idx, ev.data, ei, ed);
            end
        end
    endtask

    task automatic test_fair_order();
        ev_t ev;
        int  ei;
        logic [8:0] ed;
        int  order [5];
        order = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < 4; i++) post(i, 1'b0, 8'h40 + 8'(i), 9'h0);
        for (int i = 0; i < 5; i++) expect_done(order[i], pat(8'h40 + 8'(order[i])));
        run_until(5, 1'b1, 1'b0, 40, "t2_gnt");
        req = 4'b0;
        run_until(5, 1'b0, 1'b0, 20, "t2_done");
        for (int i = 0; i < 5 && i < gnt_log.size(); i++) begin
            n_cmp++;
            if (gnt_log[i].idx !== order[i]) begin
                n_bad++;
                $display("FAIL t2_order[%0d]: granted %0d required %0d", i, gnt_log[i].idx, order[i]);
            end
            if (i > 0) begin
                n_cmp++;
                if (gnt_log[i].cyc - gnt_log[i-1].cyc != 3) begin
                    n_bad++;
                    $display("FAIL t2_spacing[%0d]: %0d cycles required 3", i,
                             gnt_log[i].cyc - gnt_log[i-1].cyc);
                end
            end
        end
        while (exp_idx.size() > 0 && done_log.size() > 0) begin
            ev = done_log.pop_front();
            ei = exp_idx.pop_front();
            ed = exp_dat.pop_front();
            n_cmp++;
            if (ev.idx !== ei || ev.data !== ed) begin
                n_bad++;
                $display("FAIL t2_sb: idx %0d data %h required idx %0d data %h", ev.idx, ev.data, ei, ed);
            end
        end
    endtask

    task automatic test_write_read();
        ev_t ev;
        int  ei;
        logic [8:0] ed;
        do_reset();
        post(0, 1'b0, 8'h23, 9'h0);
        post(1, 1'b1, 8'h11, 9'h001);
        post(2, 1'b0, 8'h11, 9'h0);
        expect_done(0, 9'h005);
        expect_done(1, 9'h005);
        expect_done(2, 9'h001);
        run_until(3, 1'b0, 1'b1, 30, "t3_done");
        n_cmp++;
        if (we_log.size() != 1 || gnt_log.size() < 2 || we_log[0] != gnt_log[1].cyc) begin
            n_bad++;
            $display("FAIL t3_we: %0d write cycles, required exactly one in the ISSUE cycle of requester 1",
                     we_log.size());
        end
        while (exp_idx.size() > 0 && done_log.size() > 0) begin
            ev = done_log.pop_front();
            ei = exp_idx.pop_front();
            ed = exp_dat.pop_front();
            n_cmp++;
            if (ev.idx !== ei || ev.data !== ed) begin
                n_bad++;
                $display("FAIL t3_sb: idx %0d data %h required idx %0d data %h", ev.idx, ev.data, ei, ed);
            end
        end
    endtask

    task automatic test_priority();
        ev_t ev;
        int  ei;
        logic [8:0] ed;
        int  order [4];
`ifdef PLAYER_PRIORITY_EN
        order = '{0, 0, 0, 0};
`else
        order = '{0, 2, 0, 2};
`endif
        do_reset();
        post(0, 1'b0, 8'h60, 9'h0);
        post(2, 1'b0, 8'h62, 9'h0);
        for (int i = 0; i < 4; i++) expect_done(order[i], pat(8'h60 + 8'(order[i])));
        run_until(4, 1'b1, 1'b0, 30, "t4_gnt");
        req = 4'b0;
        run_until(4, 1'b0, 1'b0, 20, "t4_done");
        for (int i = 0; i < 4 && i < gnt_log.size(); i++) begin
            n_cmp++;
            if (gnt_log[i].idx !== order[i]) begin
                n_bad++;
                $display("FAIL t4_order[%0d]: granted %0d required %0d", i, gnt_log[i].idx, order[i]);
            end
        end
        while (exp_idx.size() > 0 && done_log.size() > 0) begin
            ev = done_log.pop_front();
            ei = exp_idx.pop_front();
            ed = exp_dat.pop_front();
            n_cmp++;
            if (ev.idx !== ei || ev.data !== ed) begin
                n_bad++;
                $display("FAIL t4_sb: idx %0d data %h required idx %0d data %h", ev.idx, ev.data, ei, ed);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        ev_t ev;
        int  ei;
        logic [8:0] ed;
        do_reset();
        post(1, 1'b0, 8'h50, 9'h0);
        run_until(1, 1'b1, 1'b1, 10, "t5_gnt");
        step();
        n_cmp++;
        if (busy !== 1'b1 || bram_en !== 1'b0) begin
            n_bad++;
            $display("FAIL t5_in_wait: busy %b en %b required 1 0", busy, bram_en);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({gnt, done, bram_en, bram_we, busy} !== 11'b0 || bram_addr !== 8'h0 || rdata !== 9'h0) begin
            n_bad++;
            $display("FAIL t5_async: ctrl %b addr %h rdata %h required all 0",
                     {gnt, done, bram_en, bram_we, busy}, bram_addr, rdata);
        end
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step();
        n_cmp++;
        if (done_log.size() != 0) begin
            n_bad++;
            $display("FAIL t5_no_done: %0d done pulses required 0", done_log.size());
        end
        gnt_log.delete();
        post(3, 1'b0, 8'h70, 9'h0);
        expect_done(3, pat(8'h70));
        run_until(1, 1'b1, 1'b1, 10, "t5_gnt3");
        n_cmp++;
        if (gnt_log.size() < 1 || gnt_log[0].idx !== 3) begin
            n_bad++;
            $display("FAIL t5_first: granted %0d required 3", gnt_log.size() > 0 ? gnt_log[0].idx : -1);
        end
        run_until(1, 1'b0, 1'b0, 10, "t5_done3");
        while (exp_idx.size() > 0 && done_log.size() > 0) begin
            ev = done_log.pop_front();
            ei = exp_idx.pop_front();
            ed = exp_dat.pop_front();
            n_cmp++;
            if (ev.idx !== ei || ev.data !== ed) begin
                n_bad++;
                $display("FAIL t5_sb: idx %0d data %h required idx %0d data %h", ev.idx, ev.data, ei, ed);
            end
        end
    endtask

    task automatic test_en_gating();
        ev_t ev;
        int  ei;
        logic [8:0] ed;
        do_reset();
        post(0, 1'b0, 8'h23, 9'h0);
        expect_done(0, 9'h005);
        run_until(1, 1'b1, 1'b1, 10, "t6_gnt0");
        en = 1'b0;
        post(2, 1'b0, 8'h30, 9'h0);
        expect_done(2, pat(8'h30));
        run_until(1, 1'b0, 1'b0, 10, "t6_done0");
        for (int i = 0; i < 6; i++) step();
        n_cmp++;
        if (gnt_log.size() != 1 || gnt !== 4'b0) begin
            n_bad++;
            $display("FAIL t6_no_gnt: %0d grants required 1", gnt_log.size());
        end
        en = 1'b1;
        step();
        n_cmp++;
        if (gnt !== 4'b0100) begin
            n_bad++;
            $display("FAIL t6_resume: gnt %b required 0100", gnt);
        end
        req[2] = 1'b0;
        run_until(2, 1'b0, 1'b0, 10, "t6_done2");
        while (exp_idx.size() > 0 && done_log.size() > 0) begin
            ev = done_log.pop_front();
            ei = exp_idx.pop_front();
            ed = exp_dat.pop_front();
            n_cmp++;
            if (ev.idx !== ei || ev.data !== ed) begin
                n_bad++;
                $display("FAIL t6_sb: idx %0d data %h required idx %0d data %h", ev.idx, ev.data, ei, ed);
            end
        end
    endtask

    task automatic test_lat3();
        int g, d, c;
        do_reset();
        g = -1;
        d = -1;
        x_req          = 4'b0001;
        x_addr[7:0]    = 8'h23;
        c = 0;
        while (x_gnt == 4'b0 && c < 10) begin
            step();
            c++;
        end
        if (x_gnt != 4'b0) g = cyc;
        x_req = 4'b0;
        c = 0;
        while (x_done == 4'b0 && c < 12) begin
            step();
            c++;
        end
        if (x_done != 4'b0) d = cyc;
        n_cmp++;
        if (g < 0 || d < 0 || d - g != 4) begin
            n_bad++;
            $display("FAIL lat3_timing: gnt at %0d done at %0d required 4 cycles apart", g, d);
        end
        n_cmp++;
        if (x_done !== 4'b0001 || x_rdata !== pat(8'h23)) begin
            n_bad++;
            $display("FAIL lat3_data: done %b rdata %h required 0001 %h", x_done, x_rdata, pat(8'h23));
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_fair_order();
        test_write_read();
        test_priority();
        test_reset_in_wait();
        test_en_gating();
        test_lat3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
